ap_ctrl_driver: RTL and testbench
=================================

# ap_ctrl_driver

Synthesizable initiator for the HLS `ap_ctrl_chain` block-level handshake, i.e. the driving end of the `ap_start`/`ap_ready`/`ap_done`/`ap_continue` protocol our dataflow monitors only observe. On a `go` pulse it issues `cfg_num_txn` back-to-back starts to one kernel, including overlapped starts where the kernel allows it. It accepts every `ap_done` and measures per-transaction latency with a timestamp FIFO. It sits between the test/control logic and a `cpu`-style HLS top, and exposes counters the sample manager can read in place of post-processed CSV.

## Interface
Parameters:
- `CNT_W`, 32: width of the cycle counter, transaction counters and latency outputs.
- `DEPTH`, 4: maximum number of transactions outstanding (started but not done). Must be a power of two, ≥1.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `go` in 1: single-cycle start of a run. Ignored unless the FSM is in IDLE.
- `abort` in 1: synchronous cancel of the current run.
- `cfg_num_txn` in CNT_W: number of transactions. Sampled on an accepted `go`.
- `sink_stall` in 1: holds off completion acceptance while high.
- `ap_start` out 1: registered kernel start request.
- `ap_ready` in 1: kernel has accepted the start.
- `ap_done` in 1: kernel result valid. The kernel holds it until `ap_continue`.
- `ap_continue` out 1: completion acceptance.
- `busy` out 1: high in RUN or DRAIN.
- `run_done` out 1: one-cycle pulse when a run completes or is aborted.
- `txn_issued`, `txn_done` out CNT_W: counts for the current run.
- `last_lat`, `max_lat` out CNT_W: latency statistics for the current run.
- `proto_err` out 1: sticky error flag. Cleared by reset or by an accepted `go`.

## Operation
- Free-running cycle counter `cyc`. Wraps modulo 2^CNT_W.
- An accept occurs when `ap_start & ap_ready` are high in the same cycle. A done occurs when `ap_done & ap_continue` are high in the same cycle.
- FSM states are IDLE, RUN and DRAIN:
  - IDLE to RUN on `go` when `cfg_num_txn`≠0. The same edge clears all counters, `max_lat` and `proto_err`, and latches the transaction count as N.
  - IDLE on `go` with `cfg_num_txn`=0: stay in IDLE, pulse `run_done` the next cycle, and clear the counters.
  - RUN to DRAIN when the accept that makes `txn_issued`=N occurs.
  - DRAIN to IDLE on the done that makes `txn_done`=N. `run_done` pulses the next cycle.
  - `abort` in RUN or DRAIN: go to IDLE, drop `ap_start`, flush the FIFO, pulse `run_done`. Counters hold their final values. `abort` wins over a simultaneous `go`, accept or done.
- On each accept, push `cyc` into the timestamp FIFO and increment `txn_issued`.
- On each done:
  - Pop the FIFO.
  - `last_lat` = (`cyc` − popped timestamp) mod 2^CNT_W.
  - `max_lat` = max(`max_lat`, `last_lat`).
  - Increment `txn_done`.
- A push and a pop in the same cycle are both performed; occupancy is unchanged.
- A done with the FIFO empty, or seen in IDLE: set `proto_err`, do not pop, do not count.
- `ap_start` next-state = (next state is RUN) && (`txn_issued`_next < N) && (occupancy_next < DEPTH). With the FIFO full, `ap_start` stays low until a pop.
- `ap_continue` = `busy & ~sink_stall`. Combinational from registers and the input.
- `ap_ready` without `ap_start` is ignored and is not an error.

## Timing
- All outputs reset to 0. The FSM resets to IDLE, the FIFO to empty, and `cyc` to 0.
- `go` in cycle t: `busy` and `ap_start` are high at t+1.
- With the kernel returning `ap_ready` in the same cycle as `ap_start`, `ap_start` stays high continuously. One transaction is issued per cycle until N are issued or the FIFO fills.
- An accept in cycle a paired with a done in cycle d gives `last_lat` = d−a, visible at d+1. The minimum value is 1.
- An accept and a done for different transactions may occur in the same cycle.
- `reset` asserted mid-run clears everything immediately. `ap_start` drops asynchronously.

## Structure
- Package `ap_drv_pkg`:
  - `drv_state_e` enum for IDLE/RUN/DRAIN.
  - Default `CNT_W`.
  - Function `lat_calc(cyc, ts)` returning the modular difference.
- Sub-module `ap_ts_fifo #(W, DEPTH)`:
  - Register-based FIFO with pointer-wrap occupancy count.
  - Outputs `full`, `empty` and `count`.
  - Synchronous `flush` input.
  - Simultaneous push and pop are legal, including when full.

## Test plan
- N=1, kernel asserts `ap_ready` with `ap_start` at cycle 3 and `ap_done` at cycle 10 → `last_lat`=7, `max_lat`=7, `txn_done`=1, single `run_done` pulse, then IDLE.
- N=8, DEPTH=4, kernel ready every cycle, done 6 cycles after each accept → `ap_start` drops after 4 accepts, resumes on the first pop, all `last_lat`=6, `txn_issued`=`txn_done`=8.
- `sink_stall` held high for 5 cycles while `ap_done` is high → no pop; latency grows by 5; `ap_done` held throughout; no `proto_err`.
- Spurious `ap_done` with the FIFO empty → `proto_err`=1, `txn_done` unchanged. The next `go` clears it.
- `abort` with 3 outstanding during N=10 → `run_done` pulse, `ap_start` low, FIFO empty, `txn_issued`=3 held. `go` with `cfg_num_txn`=0 → `run_done` pulse without `busy` ever going high.
- Async `reset` low mid-DRAIN, asserted between clock edges → all outputs 0 before the next edge.

Source files
------------

// File: rtl/ap_drv_pkg.sv
// rtl/ap_drv_pkg.sv - shared types and helpers for the ap_ctrl_chain driver
package ap_drv_pkg;

  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } drv_state_e;

  // Callers truncate the result to their counter width; the low bits of a
  // wide subtraction are the modular difference at any narrower width.
  function automatic logic [63:0] lat_calc(input logic [63:0] cyc, input logic [63:0] ts);
    return cyc - ts;
  endfunction

endpackage

// File: rtl/ap_ctrl_driver_if.sv
// rtl/ap_ctrl_driver_if.sv - ap_ctrl_chain block-level handshake bundle
interface ap_ctrl_driver_if;

  logic ap_start;
  logic ap_ready;
  logic ap_done;
  logic ap_continue;

  modport master (output ap_start, output ap_continue, input ap_ready, input ap_done);
  modport slave  (input ap_start, input ap_continue, output ap_ready, output ap_done);

endinterface

// File: rtl/ap_ts_fifo.sv
// rtl/ap_ts_fifo.sv - register FIFO of start timestamps with wrap-bit occupancy
module ap_ts_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          do_push;
  logic          do_pop;

  // Pointers carry one extra bit so full and empty differ by the wrap bit.
  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == PW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign wr_idx  = AW'(wr_ptr % PW'(DEPTH));
  assign rd_idx  = AW'(rd_ptr % PW'(DEPTH));
  assign rdata   = mem[rd_idx];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_idx] <= wdata;
  end

endmodule

// File: rtl/ap_ctrl_driver.sv
// rtl/ap_ctrl_driver.sv - ap_ctrl_chain initiator issuing N starts and measuring latency
module ap_ctrl_driver
  import ap_drv_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 go,
  input  logic                 abort,
  input  logic [CNT_W-1:0]     cfg_num_txn,
  input  logic                 sink_stall,
  ap_ctrl_driver_if.master     ap,
  output logic                 busy,
  output logic                 run_done,
  output logic [CNT_W-1:0]     txn_issued,
  output logic [CNT_W-1:0]     txn_done,
  output logic [CNT_W-1:0]     last_lat,
  output logic [CNT_W-1:0]     max_lat,
  output logic                 proto_err
);

  localparam int OW = $clog2(DEPTH) + 1;

  drv_state_e     state, state_next;
  logic [CNT_W-1:0] cyc, num_txn, n_eff, issued_next, head_ts, lat;
  logic [OW-1:0]  occ, occ_next;
  logic           start_q, start_next, run_done_next;
  logic           idle_go, abort_run, accept, done_hs, push, pop, err, finish;
  logic           fifo_full, fifo_empty;

  assign busy           = (state != ST_IDLE);
  assign ap.ap_start    = start_q;
  assign ap.ap_continue = busy & ~sink_stall;

  // Abort takes priority: any handshake seen in the abort cycle is discarded.
  assign idle_go   = go & (state == ST_IDLE);
  assign abort_run = abort & busy;
  assign accept    = start_q & ap.ap_ready & ~abort_run;
  assign done_hs   = ap.ap_done & ap.ap_continue;
  assign push      = accept & (~fifo_full | pop);
  assign pop       = done_hs & busy & ~fifo_empty & ~abort_run;
  assign err       = done_hs & (~busy | fifo_empty) & ~abort_run;
  assign finish    = pop & ((txn_done + CNT_W'(1)) == num_txn);
  assign lat       = CNT_W'(lat_calc(64'(cyc), 64'(head_ts)));

  ap_ts_fifo #(.W(CNT_W), .DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (abort_run | idle_go),
    .push  (push),
    .pop   (pop),
    .wdata (cyc),
    .rdata (head_ts),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (occ)
  );

  always_comb begin
    state_next    = state;
    run_done_next = 1'b0;
    issued_next   = txn_issued + CNT_W'(accept);
    occ_next      = occ + OW'(push) - OW'(pop);
    n_eff         = num_txn;
    case (state)
      ST_IDLE: begin
        if (go) begin
          issued_next = '0;
          occ_next    = '0;
          n_eff       = cfg_num_txn;
          if (cfg_num_txn != '0) state_next = ST_RUN;
          else                   run_done_next = 1'b1;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_next    = ST_IDLE;
          run_done_next = 1'b1;
        end else if (accept && (issued_next == num_txn)) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (abort || finish) begin
          state_next    = ST_IDLE;
          run_done_next = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    start_next = (state_next == ST_RUN) && (issued_next < n_eff) && (occ_next < OW'(DEPTH));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      start_q  <= 1'b0;
      run_done <= 1'b0;
    end else begin
      state    <= state_next;
      start_q  <= start_next;
      run_done <= run_done_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cyc        <= '0;
      num_txn    <= '0;
      txn_issued <= '0;
      txn_done   <= '0;
      last_lat   <= '0;
      max_lat    <= '0;
      proto_err  <= 1'b0;
    end else begin
      cyc <= cyc + CNT_W'(1);
      if (idle_go) begin
        num_txn    <= cfg_num_txn;
        txn_issued <= '0;
        txn_done   <= '0;
        last_lat   <= '0;
        max_lat    <= '0;
        proto_err  <= 1'b0;
      end else begin
        if (accept) txn_issued <= txn_issued + CNT_W'(1);
        if (pop) begin
          txn_done <= txn_done + CNT_W'(1);
          last_lat <= lat;
          if (lat > max_lat) max_lat <= lat;
        end
        if (err) proto_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ap_ctrl_driver.sv
// tb/tb_ap_ctrl_driver.sv - bench for ap_ctrl_driver with a kernel model and transaction scoreboard
module tb_ap_ctrl_driver;

  localparam int CW = 32;
  localparam int DP = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          go = 1'b0;
  logic          abort = 1'b0;
  logic          sink_stall = 1'b0;
  logic [CW-1:0] cfg_num_txn = '0;
  logic          busy, run_done, proto_err;
  logic [CW-1:0] txn_issued, txn_done, last_lat, max_lat;

  ap_ctrl_driver_if bus ();

  ap_ctrl_driver #(.CNT_W(CW), .DEPTH(DP)) dut (
    .clock       (clock),
    .reset       (reset),
    .go          (go),
    .abort       (abort),
    .cfg_num_txn (cfg_num_txn),
    .sink_stall  (sink_stall),
    .ap          (bus.master),
    .busy        (busy),
    .run_done    (run_done),
    .txn_issued  (txn_issued),
    .txn_done    (txn_done),
    .last_lat    (last_lat),
    .max_lat     (max_lat),
    .proto_err   (proto_err)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: run bookkeeping and a queue of start times
  int            tcyc = 0;
  int            q_ts[$];
  bit            m_busy = 0, m_perr = 0, m_rd = 0;
  int            m_n = 0, m_issued = 0, m_done = 0;
  logic [CW-1:0] m_last = '0, m_max = '0;

  // Kernel model: in-order completion times
  int k_rel[$];
  int k_ready_pct = 100, k_dmin = 1, k_dmax = 1;
  int stall_len = 0, stall_cnt = 0;
  bit stall_rand = 0, force_done = 0;

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("ap_start", bus.ap_start, m_busy && (m_issued < m_n) && (q_ts.size() < DP));
    chk("busy", busy, m_busy);
    chk("run_done", run_done, m_rd);
    chk("txn_issued", txn_issued, m_issued);
    chk("txn_done", txn_done, m_done);
    chk("last_lat", last_lat, m_last);
    chk("max_lat", max_lat, m_max);
    chk("proto_err", proto_err, m_perr);
  endtask

  task automatic model_reset();
    q_ts.delete();
    k_rel.delete();
    m_busy = 0; m_perr = 0; m_rd = 0;
    m_n = 0; m_issued = 0; m_done = 0;
    m_last = '0; m_max = '0;
  endtask

  // Entered and left at a falling edge.
  task automatic cycle(input bit g, input logic [CW-1:0] n, input bit ab);
    bit acc, dn;
    int ts;
    check_outputs();
    go = g; cfg_num_txn = n; abort = ab;
    bus.ap_ready = ($urandom_range(0, 99) < k_ready_pct);
    bus.ap_done  = force_done | ((k_rel.size() > 0) && (k_rel[0] <= tcyc));
    if (stall_len > 0 && bus.ap_done && stall_cnt < stall_len) begin
      sink_stall = 1'b1;
      stall_cnt++;
    end else begin
      sink_stall = stall_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
    #1;
    chk("ap_continue", bus.ap_continue, m_busy & ~sink_stall);
    acc = bus.ap_start & bus.ap_ready;
    dn  = bus.ap_done & bus.ap_continue;
    if (dn && !force_done && k_rel.size() > 0) void'(k_rel.pop_front());
    if (acc) k_rel.push_back(tcyc + int'($urandom_range(k_dmin, k_dmax)));
    m_rd = 0;
    if (ab && m_busy) begin
      m_busy = 0; m_rd = 1;
      q_ts.delete();
    end else if (m_busy) begin
      if (dn) begin
        if (q_ts.size() == 0) m_perr = 1;
        else begin
          ts = q_ts.pop_front();
          m_last = CW'(tcyc - ts);
          if (m_last > m_max) m_max = m_last;
          m_done++;
        end
      end
      if (acc) begin
        q_ts.push_back(tcyc);
        m_issued++;
      end
      if (m_done == m_n) begin
        m_busy = 0; m_rd = 1;
      end
    end else if (g) begin
      q_ts.delete();
      m_issued = 0; m_done = 0; m_last = '0; m_max = '0; m_perr = 0;
      if (n == '0) m_rd = 1;
      else begin
        m_busy = 1; m_n = int'(n);
      end
    end
    tcyc++;
    @(posedge clock);
    @(negedge clock);
    go = 1'b0; abort = 1'b0;
  endtask

  task automatic run_until_idle(input int budget);
    for (int i = 0; i < budget && m_busy; i++) cycle(1'b0, '0, 1'b0);
    chk("run_timeout", busy, 1'b0);
    if (m_busy) cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
  endtask

  initial begin
    bus.ap_ready = 1'b0;
    bus.ap_done  = 1'b0;
    repeat (2) @(negedge clock);
    check_outputs();
    chk("rst_ap_continue", bus.ap_continue, 1'b0);
    reset = 1'b1;

    // single transaction, latency 7
    k_ready_pct = 100; k_dmin = 7; k_dmax = 7;
    cycle(1'b1, 1, 1'b0);
    run_until_idle(50);
    chk("t1_last", last_lat, 7);
    chk("t1_max", max_lat, 7);
    chk("t1_done", txn_done, 1);

    // eight transactions against a four-deep FIFO
    k_dmin = 6; k_dmax = 6;
    cycle(1'b1, 8, 1'b0);
    run_until_idle(100);
    chk("t2_last", last_lat, 6);
    chk("t2_max", max_lat, 6);
    chk("t2_issued", txn_issued, 8);
    chk("t2_done", txn_done, 8);

    // sink stall stretches the measured latency
    k_dmin = 3; k_dmax = 3; stall_len = 5; stall_cnt = 0;
    cycle(1'b1, 1, 1'b0);
    run_until_idle(50);
    chk("t3_last", last_lat, 8);
    chk("t3_perr", proto_err, 1'b0);
    stall_len = 0;

    // spurious done with nothing outstanding
    k_ready_pct = 0;
    cycle(1'b1, 3, 1'b0);
    force_done = 1'b1;
    cycle(1'b0, '0, 1'b0);
    force_done = 1'b0;
    chk("t4_perr", proto_err, 1'b1);
    chk("t4_done", txn_done, 0);
    cycle(1'b0, '0, 1'b1);
    k_rel.delete();
    k_ready_pct = 100; k_dmin = 2; k_dmax = 2;
    cycle(1'b1, 1, 1'b0);
    chk("t4_perr_clr", proto_err, 1'b0);
    run_until_idle(50);

    // abort with three outstanding
    k_dmin = 20; k_dmax = 20;
    cycle(1'b1, 10, 1'b0);
    for (int i = 0; i < 50 && m_issued < 3; i++) cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b1);
    k_rel.delete();
    chk("t5_run_done", run_done, 1'b1);
    chk("t5_ap_start", bus.ap_start, 1'b0);
    chk("t5_issued", txn_issued, 3);
    chk("t5_busy", busy, 1'b0);
    cycle(1'b0, '0, 1'b0);

    // zero-length run
    cycle(1'b1, 0, 1'b0);
    chk("t6_run_done", run_done, 1'b1);
    chk("t6_busy", busy, 1'b0);
    cycle(1'b0, '0, 1'b0);

    // randomized runs
    stall_rand = 1;
    for (int r = 0; r < 8; r++) begin
      k_ready_pct = int'($urandom_range(30, 100));
      k_dmin = 1;
      k_dmax = int'($urandom_range(1, 8));
      cycle(1'b1, CW'($urandom_range(1, 12)), 1'b0);
      run_until_idle(600);
    end
    stall_rand = 0;

    // asynchronous reset while draining
    k_ready_pct = 100; k_dmin = 10; k_dmax = 10;
    cycle(1'b1, 2, 1'b0);
    for (int i = 0; i < 20 && m_issued < 2; i++) cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0);
    chk("t7_in_drain", busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("t7_ap_start", bus.ap_start, 1'b0);
    chk("t7_busy", busy, 1'b0);
    chk("t7_ap_continue", bus.ap_continue, 1'b0);
    chk("t7_issued", txn_issued, 0);
    chk("t7_last", last_lat, 0);
    chk("t7_max", max_lat, 0);
    model_reset();
    bus.ap_ready = 1'b0;
    bus.ap_done  = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
